conv1d_stream_param: RTL and testbench
======================================

Name: conv1d_stream_param

Overview:
- Parametrised successor to the fixed-size convolution units: 1-D valid-mode convolution with runtime-loadable filter, stride and saturating fixed-point MAC.
- Per frame it accepts an N-sample input vector and an M-tap filter on two independent valid/ready streams, then emits (N-M)/S+1 results on a valid/ready output stream.
- Sits between a stream source, such as a previous layer or DMA, and the next layer.

Parameters:
- N, 32, input vector length per frame (≥ M).
- M, 8, filter taps per frame (≥ 2).
- S, 1, stride; (N-M) mod S must be 0, else elaboration error.
- T, 16, signed sample/coefficient/result width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- x_data  in  T  signed input sample.
- x_valid  in  1  x_data valid.
- x_ready  out  1  block accepts x sample.
- f_data  in  T  signed filter coefficient.
- f_valid  in  1  f_data valid.
- f_ready  out  1  block accepts coefficient.
- y_data  out  T  signed result.
- y_valid  out  1  y_data valid.
- y_ready  in  1  downstream accepts result.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n). All flops clear immediately on reset_n low.
- Reset values: state=INIT, all counters 0, accumulator 0, x_ready=0, f_ready=0, y_valid=0, y_data=0.
- States and transitions:
  - INIT: ready outputs low; advances to LOAD after 1 cycle.
  - LOAD: x_ready=1 until N samples accepted; f_ready=1 until M coefficients accepted. Streams are independent and may interleave or be simultaneous. Writes go to addresses 0..N-1 and 0..M-1 in arrival order. When both counts are complete, go to COMPUTE with k=0.
  - COMPUTE: M cycles issuing x address k·S+j and f address j, for j=0..M-1. Then DRAIN.
  - DRAIN: 2 cycles covering the synchronous memory read and the product pipeline register, accumulator enabled. Then OUT.
  - OUT: y_valid=1; y_data is held stable until y_ready. On handshake the accumulator clears. If k < (N-M)/S, then k=k+1 and go to COMPUTE; else go to LOAD for a new frame (both memories reloaded).
- Latency:
  - y_valid rises exactly M+2 cycles after the first COMPUTE cycle of each output.
  - With y_ready held high, the output period is M+3 cycles.
  - The first output appears M+3 cycles after the last LOAD handshake.
- Arithmetic:
  - Product is 2T bits signed, saturated to T bits [-2^(T-1), 2^(T-1)-1], then registered.
  - Accumulator is T bits; each add is computed in T+1 bits and saturated to T bits.
  - Saturation is applied per step (not once at the end).
- Boundaries:
  - Extra x or f beats after a count is complete are not accepted (ready low).
  - No input is accepted outside LOAD.
  - A y_ready pulse while y_valid=0 is ignored.
  - Counters wrap to 0 at frame end.
  - reset_n asserted mid-COMPUTE/OUT discards the frame; after release the block re-enters INIT→LOAD, with no stale output.
  - The y_valid/y_data hold rule applies under arbitrary y_ready stalls.

Optional Feature:
- CONV_RELU_EN
  - Defined: y_data = 0 when the saturated accumulator is negative, else the accumulator value.
  - Undefined: y_data is the signed saturated accumulator value unchanged.
  - Arithmetic, latency and handshakes are identical in both builds.

Test Plan:
1. Defaults; x[i]=1 for all i, f[j]=2 for all j; y_ready=1 → 25 outputs, each 16, spaced 11 cycles apart.
2. x[i]=32767, f[j]=32767 → every y=32767 (product and accumulator saturation).
3. x[i]=1, f[j]=-3 → y=-24 without CONV_RELU_EN; y=0 with it.
4. S=2; x[i]=i, f={1,0,0,0,0,0,0,0} → 13 outputs y_k=2k (0,2,…,24), then x_ready=1 (next frame).
5. Defaults, test 1 data, y_ready low 10 cycles on output 3 → y_valid held, y_data=16 stable, 25 outputs total, none lost or duplicated.
6. Interleaved random x_valid/f_valid gaps, reset_n low during COMPUTE of output 5 → y_valid=0 immediately; a fresh frame afterwards produces correct results for all 25 outputs.

Source files
------------

// File: rtl/conv1d_stream_param.sv
// Streaming 1-D valid-mode convolution: loads N samples and M taps, emits (N-M)/S+1
// saturated results. Define CONV_RELU_EN to clamp negative results to zero.
module conv1d_stream_param #(
  parameter int N = 32,
  parameter int M = 8,
  parameter int S = 1,
  parameter int T = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  input  logic signed [T-1:0] f_data,
  input  logic                f_valid,
  output logic                f_ready,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready
);

  localparam int KMAX = (N - M) / S;
  localparam int XAW  = $clog2(N);
  localparam int FAW  = $clog2(M);
  localparam int XCW  = $clog2(N + 1);
  localparam int FCW  = $clog2(M + 1);
  localparam int KW   = (KMAX > 0) ? $clog2(KMAX + 1) : 1;

  localparam logic [XCW-1:0] X_CNT_FULL = XCW'(N);
  localparam logic [FCW-1:0] F_CNT_FULL = FCW'(M);
  localparam logic [FAW-1:0] J_LAST     = FAW'(M - 1);
  localparam logic [KW-1:0]  K_LAST     = KW'(KMAX);
  localparam logic [XAW-1:0] S_STEP     = XAW'(S);

  localparam logic signed [T-1:0] MAX_T = {1'b0, {(T-1){1'b1}}};
  localparam logic signed [T-1:0] MIN_T = {1'b1, {(T-1){1'b0}}};

  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_OUT     = 3'd4;

  if ((N - M) % S != 0) begin : g_bad_stride
    $error("conv1d_stream_param: (N-M) must be a multiple of S");
  end
  if (M < 2 || N < M) begin : g_bad_size
    $error("conv1d_stream_param: need M >= 2 and N >= M");
  end

  function automatic logic signed [T-1:0] sat_prod(input logic signed [2*T-1:0] p);
    if (p > (2*T)'(MAX_T)) return MAX_T;
    if (p < (2*T)'(MIN_T)) return MIN_T;
    return p[T-1:0];
  endfunction

  function automatic logic signed [T-1:0] sat_add(input logic signed [T-1:0] a,
                                                  input logic signed [T-1:0] b);
    logic signed [T:0] s;
    s = {a[T-1], a} + {b[T-1], b};
    if (s[T] != s[T-1]) return s[T] ? MIN_T : MAX_T;
    return s[T-1:0];
  endfunction

  logic [2:0]          state_q, state_d;
  logic [XCW-1:0]      x_cnt_q, x_cnt_d;
  logic [FCW-1:0]      f_cnt_q, f_cnt_d;
  logic [FAW-1:0]      j_q, j_d;
  logic [KW-1:0]       k_q, k_d;
  logic [XAW-1:0]      base_q, base_d;
  logic                drain_q, drain_d;
  logic signed [T-1:0] acc_q, acc_d;
  logic signed [T-1:0] prod_q;
  logic signed [T-1:0] x_rd_q, f_rd_q;
  logic                rd_vld_q, prod_vld_q;

  logic signed [T-1:0]   x_mem [N];
  logic signed [T-1:0]   f_mem [M];
  logic signed [2*T-1:0] prod_full;
  logic signed [T-1:0]   y_res;
  logic [XAW-1:0]        x_addr;
  logic                  x_fire, f_fire, y_fire;

  assign x_ready   = (state_q == ST_LOAD) && (x_cnt_q != X_CNT_FULL);
  assign f_ready   = (state_q == ST_LOAD) && (f_cnt_q != F_CNT_FULL);
  assign x_fire    = x_valid && x_ready;
  assign f_fire    = f_valid && f_ready;
  assign y_valid   = (state_q == ST_OUT);
  assign y_fire    = y_valid && y_ready;
  assign x_addr    = base_q + XAW'(j_q);
  assign prod_full = (2*T)'(x_rd_q) * (2*T)'(f_rd_q);

`ifdef CONV_RELU_EN
  assign y_res = acc_q[T-1] ? '0 : acc_q;
`else
  assign y_res = acc_q;
`endif
  assign y_data = y_valid ? y_res : '0;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    state_d = state_q;
    x_cnt_d = x_cnt_q;
    f_cnt_d = f_cnt_q;
    j_d     = j_q;
    k_d     = k_q;
    base_d  = base_q;
    drain_d = drain_q;
    acc_d   = acc_q;

    case (state_q)
      ST_INIT: state_d = ST_LOAD;
      ST_LOAD: begin
        if (x_fire) x_cnt_d = x_cnt_q + 1'b1;
        if (f_fire) f_cnt_d = f_cnt_q + 1'b1;
        // Leave on the handshake cycle itself so COMPUTE starts one cycle after it.
        if (x_cnt_d == X_CNT_FULL && f_cnt_d == F_CNT_FULL) begin
          state_d = ST_COMPUTE;
          x_cnt_d = '0;
          f_cnt_d = '0;
          j_d     = '0;
        end
      end
      ST_COMPUTE: begin
        if (j_q == J_LAST) begin
          j_d     = '0;
          drain_d = 1'b0;
          state_d = ST_DRAIN;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (y_ready) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            base_d  = '0;
            state_d = ST_LOAD;
          end else begin
            k_d     = k_q + 1'b1;
            base_d  = base_q + S_STEP;
            state_d = ST_COMPUTE;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (prod_vld_q) acc_d = sat_add(acc_q, prod_q);
    if (y_fire)     acc_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      x_cnt_q    <= '0;
      f_cnt_q    <= '0;
      j_q        <= '0;
      k_q        <= '0;
      base_q     <= '0;
      drain_q    <= 1'b0;
      acc_q      <= '0;
      prod_q     <= '0;
      x_rd_q     <= '0;
      f_rd_q     <= '0;
      rd_vld_q   <= 1'b0;
      prod_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_cnt_q    <= x_cnt_d;
      f_cnt_q    <= f_cnt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      base_q     <= base_d;
      drain_q    <= drain_d;
      acc_q      <= acc_d;
      x_rd_q     <= x_mem[x_addr];
      f_rd_q     <= f_mem[j_q];
      rd_vld_q   <= (state_q == ST_COMPUTE);
      prod_q     <= sat_prod(prod_full);
      prod_vld_q <= rd_vld_q;
    end
  end

  // NOTE: sample memories carry no reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (x_fire) x_mem[x_cnt_q[XAW-1:0]] <= x_data;
    if (f_fire) f_mem[f_cnt_q[FAW-1:0]] <= f_data;
  end

endmodule

// File: tb/tb_conv1d_stream_param.sv
// Randomised self-checking bench for conv1d_stream_param (stride 1 and stride 2 instances)
// against a plain-arithmetic convolution model; honours CONV_RELU_EN.
module tb_conv1d_stream_param;
  localparam int N = 32;
  localparam int M = 8;
  localparam int T = 16;
  localparam int MAXV = 2**(T-1) - 1;
  localparam int MINV = -(2**(T-1));

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic signed [T-1:0] x_data = '0, f_data = '0;
  logic x_valid = 1'b0, f_valid = 1'b0, y_ready = 1'b0;
  int sel = 0;

  logic x_ready_a, f_ready_a, y_valid_a, x_ready_b, f_ready_b, y_valid_b;
  logic signed [T-1:0] y_data_a, y_data_b;
  logic x_ready_m, f_ready_m, y_valid_m;
  logic signed [T-1:0] y_data_m;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  conv1d_stream_param #(.N(N), .M(M), .S(1), .T(T)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .x_data(x_data), .x_valid(x_valid && (sel == 0)), .x_ready(x_ready_a),
    .f_data(f_data), .f_valid(f_valid && (sel == 0)), .f_ready(f_ready_a),
    .y_data(y_data_a), .y_valid(y_valid_a), .y_ready(y_ready && (sel == 0)));

  conv1d_stream_param #(.N(N), .M(M), .S(2), .T(T)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .x_data(x_data), .x_valid(x_valid && (sel == 1)), .x_ready(x_ready_b),
    .f_data(f_data), .f_valid(f_valid && (sel == 1)), .f_ready(f_ready_b),
    .y_data(y_data_b), .y_valid(y_valid_b), .y_ready(y_ready && (sel == 1)));

  assign x_ready_m = (sel == 0) ? x_ready_a : x_ready_b;
  assign f_ready_m = (sel == 0) ? f_ready_a : f_ready_b;
  assign y_valid_m = (sel == 0) ? y_valid_a : y_valid_b;
  assign y_data_m  = (sel == 0) ? y_data_a  : y_data_b;

  int tests = 0, fails = 0;
  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int xv[N];
  int fv[M];
  int exp_q[$];
  int got_v[$];
  int got_t[$];
  int last_ld = 0;
  bit x_done, f_done;

  function automatic int clamp(longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return int'(v);
  endfunction

  function automatic void build_expect(int s);
    for (int k = 0; k <= (N - M) / s; k++) begin
      int acc = 0;
      for (int j = 0; j < M; j++)
        acc = clamp(longint'(acc) + clamp(longint'(xv[k*s + j]) * longint'(fv[j])));
`ifdef CONV_RELU_EN
      if (acc < 0) acc = 0;
`endif
      exp_q.push_back(acc);
    end
  endfunction

  // Compare process: scoreboard pop on each y handshake, hold rule while stalled.
  bit prev_stall = 1'b0;
  logic signed [T-1:0] prev_data = '0;
  int mon_exp;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_y_valid", y_valid_m, 1);
        check("hold_y_data", y_data_m, prev_data);
      end
      if (y_valid_m) begin
        check("x_ready_outside_load", x_ready_m, 0);
        check("f_ready_outside_load", f_ready_m, 0);
      end
      if (y_valid_m && y_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_y_beat", 1, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("y_data_vs_model", y_data_m, mon_exp);
        end
        got_v.push_back(int'(y_data_m));
        got_t.push_back(cyc + 1);
      end
      prev_stall = y_valid_m && !y_ready;
      prev_data  = y_data_m;
    end
  end

  task automatic drive_x(int gapmax, bit junk);
    for (int i = 0; i < N; i++) begin
      int w = 0;
      bit hs = 1'b0;
      repeat ($urandom_range(0, gapmax)) begin @(posedge clk); #1; end
      x_data = xv[i][T-1:0];
      x_valid = 1'b1;
      while (!hs && w < 2000) begin
        @(negedge clk); hs = x_ready_m;
        @(posedge clk); #1; w++;
      end
      if (!hs) begin check("x_handshake_timeout", 0, 1); break; end
      if (cyc > last_ld) last_ld = cyc;
      x_valid = 1'b0;
    end
    x_done = 1'b1;
    while (junk && !f_done) begin
      x_valid = 1'b1; x_data = T'($urandom);
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
  endtask

  task automatic drive_f(int gapmax, bit junk);
    for (int i = 0; i < M; i++) begin
      int w = 0;
      bit hs = 1'b0;
      repeat ($urandom_range(0, gapmax)) begin @(posedge clk); #1; end
      f_data = fv[i][T-1:0];
      f_valid = 1'b1;
      while (!hs && w < 2000) begin
        @(negedge clk); hs = f_ready_m;
        @(posedge clk); #1; w++;
      end
      if (!hs) begin check("f_handshake_timeout", 0, 1); break; end
      if (cyc > last_ld) last_ld = cyc;
      f_valid = 1'b0;
    end
    f_done = 1'b1;
    while (junk && !x_done) begin
      f_valid = 1'b1; f_data = T'($urandom);
      @(posedge clk); #1;
    end
    f_valid = 1'b0;
  endtask

  task automatic run_frame(int s, int gapmax, bit junk);
    x_done = 1'b0; f_done = 1'b0;
    build_expect(s);
    fork
      drive_x(gapmax, junk);
      drive_f(gapmax, junk);
    join
  endtask

  task automatic wait_outputs(int n);
    int w = 0;
    while (got_v.size() < n && w < 8000) begin @(posedge clk); #1; w++; end
    check("output_count", got_v.size(), n);
  endtask

  task automatic random_stall(int n);
    int w = 0;
    while (got_v.size() < n && w < 8000) begin
      @(posedge clk); #1; w++;
      y_ready = ($urandom_range(0, 3) != 0);
    end
    y_ready = 1'b1;
  endtask

  task automatic fill_const(int xc, int fc);
    for (int i = 0; i < N; i++) xv[i] = xc;
    for (int j = 0; j < M; j++) fv[j] = fc;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) xv[i] = int'($urandom_range(0, 65535)) - 32768;
    for (int j = 0; j < M; j++)
      fv[j] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 65535)) - 32768
                                          : int'($urandom_range(0, 15)) - 8;
  endtask

  int bad;
  initial begin
    // Reset state of both instances.
    repeat (3) @(posedge clk);
    #1;
    check("rst_y_valid_a", y_valid_a, 0);
    check("rst_y_data_a", y_data_a, 0);
    check("rst_x_ready_a", x_ready_a, 0);
    check("rst_f_ready_a", f_ready_a, 0);
    check("rst_y_valid_b", y_valid_b, 0);
    reset_n = 1'b1;
    #1;
    check("init_x_ready", x_ready_a, 0);
    y_ready = 1'b1;  // y_ready high with y_valid low must be ignored
    @(posedge clk); #1;
    check("load_x_ready", x_ready_a, 1);
    check("load_f_ready", f_ready_a, 1);

    // Test 1: all-ones by all-twos, back-to-back outputs.
    fill_const(1, 2);
    got_v.delete(); got_t.delete();
    run_frame(1, 0, 0);
    wait_outputs(N - M + 1);
    check("t1_y0_literal", got_v[0], 16);
    check("t1_y24_literal", got_v[24], 16);
    check("t1_first_latency", got_t[0] - last_ld, M + 3);
    bad = 0;
    for (int k = 1; k < got_t.size(); k++) if (got_t[k] - got_t[k-1] != M + 3) bad++;
    check("t1_period_violations", bad, 0);

    // Test 2: product and accumulator saturation.
    fill_const(32767, 32767);
    got_v.delete(); got_t.delete();
    run_frame(1, 1, 0);
    wait_outputs(N - M + 1);
    check("t2_saturated_literal", got_v[3], 32767);

    // Test 3: negative result, ReLU dependent.
    fill_const(1, -3);
    got_v.delete(); got_t.delete();
    run_frame(1, 2, 1);
    wait_outputs(N - M + 1);
`ifdef CONV_RELU_EN
    check("t3_negative_literal", got_v[0], 0);
`else
    check("t3_negative_literal", got_v[0], -24);
`endif

    // Test 4: stride 2 instance, identity tap at 0.
    sel = 1;
    for (int i = 0; i < N; i++) xv[i] = i;
    fill_const(0, 0);
    for (int i = 0; i < N; i++) xv[i] = i;
    fv[0] = 1;
    got_v.delete(); got_t.delete();
    run_frame(2, 1, 0);
    wait_outputs((N - M) / 2 + 1);
    check("t4_y0_literal", got_v[0], 0);
    check("t4_y6_literal", got_v[6], 12);
    check("t4_y12_literal", got_v[12], 24);
    check("t4_next_frame_x_ready", x_ready_m, 1);
    repeat (20) @(posedge clk);
    #1;
    check("t4_no_extra_outputs", got_v.size(), 13);
    sel = 0;

    // Test 5: 10-cycle stall on output 3.
    fill_const(1, 2);
    got_v.delete(); got_t.delete();
    run_frame(1, 0, 0);
    wait_outputs(2);
    y_ready = 1'b0;
    begin
      int w = 0;
      while (!y_valid_m && w < 200) begin @(posedge clk); #1; w++; end
    end
    check("t5_stall_valid_seen", y_valid_m, 1);
    repeat (10) @(posedge clk);
    #1;
    check("t5_stall_valid_held", y_valid_m, 1);
    check("t5_stall_data_held", y_data_m, 16);
    check("t5_no_beat_during_stall", got_v.size(), 2);
    y_ready = 1'b1;
    wait_outputs(N - M + 1);
    repeat (15) @(posedge clk);
    #1;
    check("t5_total_outputs", got_v.size(), 25);

    // Test 6: random gaps and extra beats, reset during COMPUTE of output 5.
    fill_random();
    got_v.delete(); got_t.delete();
    run_frame(1, 3, 1);
    wait_outputs(4);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_y_valid", y_valid_m, 0);
    check("t6_rst_y_data", y_data_m, 0);
    check("t6_rst_x_ready", x_ready_m, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    fill_random();
    got_v.delete(); got_t.delete();
    fork
      run_frame(1, 3, 1);
      random_stall(N - M + 1);
    join
    wait_outputs(N - M + 1);
    check("t6_scoreboard_empty", exp_q.size(), 0);

    // Extra random frames on both strides with random back-pressure.
    for (int r = 0; r < 4; r++) begin
      sel = r % 2;
      fill_random();
      got_v.delete(); got_t.delete();
      fork
        run_frame(sel + 1, 2, 1);
        random_stall((N - M) / (sel + 1) + 1);
      join
      wait_outputs((N - M) / (sel + 1) + 1);
      check("rand_scoreboard_empty", exp_q.size(), 0);
    end
    sel = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got %0d, expected 0", 1);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
